// File: rtl/vector_lsu_pkg.sv
// Shared types and sizing helpers for the vector load/store path.
// Imported by the load writeback packer.
package vector_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } wb_state_t;

  localparam int DEF_VREG_BITS = 64;
  localparam int DEF_BEAT_BITS = 32;
  localparam int DEF_NUM_REGS  = 32;
  localparam int DEF_MAX_GROUP = 8;

  function automatic int beats_per_reg(
    input int vreg_bits,
    input int beat_bits
  );
    return vreg_bits / beat_bits;
  endfunction

  function automatic int cnt_width(
    input int max_group,
    input int bpr
  );
    return $clog2(max_group * bpr + 1);
  endfunction

endpackage

// File: rtl/vector_load_writeback.sv
// Packs memory response beats into vector register lines and
// writes each completed line to the register file load port.
module vector_load_writeback
  import vector_lsu_pkg::*;
#(
  parameter int VREG_BITS           = DEF_VREG_BITS,
  parameter int BEAT_BITS           = DEF_BEAT_BITS,
  parameter int NUMBER_OF_REGISTERS = DEF_NUM_REGS,
  parameter int MAX_GROUP           = DEF_MAX_GROUP,
  localparam int BPR    = beats_per_reg(VREG_BITS, BEAT_BITS),
  localparam int CNT_W  = cnt_width(MAX_GROUP, BPR),
  localparam int DEST_W = $clog2(NUMBER_OF_REGISTERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [DEST_W-1:0]    req_dest,
  input  logic [CNT_W-1:0]     req_beats,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [BEAT_BITS-1:0] mem_data,
  input  logic                 kill,
  output logic                 wb_valid,
  output logic [DEST_W-1:0]    wb_dest,
  output logic [VREG_BITS-1:0] wb_data,
  output logic                 busy
);

  localparam int IDX_W = (BPR > 1) ? $clog2(BPR) : 1;

  wb_state_t            state_q;
  logic [DEST_W-1:0]    dest_q;
  logic [CNT_W-1:0]     remaining_q;
  logic [IDX_W-1:0]     beat_idx_q;
  logic [VREG_BITS-1:0] line_q;

  logic [VREG_BITS-1:0] line_ins;
  logic                 last_beat;
  logic                 beat_fire;

  assign req_ready = (state_q == IDLE);
  assign mem_ready = (state_q == COLLECT);
  assign busy      = (state_q != IDLE);
  assign beat_fire = mem_valid && mem_ready;

  // Line buffer with the incoming beat dropped into its slot
  always_comb begin
    line_ins = line_q;
    for (int i = 0; i < BPR; i++) begin
      if (beat_idx_q == IDX_W'(i)) begin
        line_ins[i*BEAT_BITS +: BEAT_BITS] = mem_data;
      end
    end
  end

  // A register closes on its last slot or on the request's last beat
  always_comb begin
    last_beat = (beat_idx_q == IDX_W'(BPR - 1))
             || (remaining_q == CNT_W'(1));
  end

  // Request / collect / write sequencer with registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      remaining_q <= '0;
      beat_idx_q  <= '0;
      line_q      <= '0;
      wb_valid    <= 1'b0;
      wb_dest     <= '0;
      wb_data     <= '0;
    end else begin
      wb_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid && (req_beats != '0)) begin
            dest_q      <= req_dest;
            remaining_q <= req_beats;
            line_q      <= '0;
            beat_idx_q  <= '0;
            state_q     <= COLLECT;
          end
        end
        COLLECT: begin
          if (kill) begin
            line_q      <= '0;
            beat_idx_q  <= '0;
            remaining_q <= '0;
            state_q     <= IDLE;
          end else if (beat_fire) begin
            line_q      <= line_ins;
            beat_idx_q  <= beat_idx_q + IDX_W'(1);
            remaining_q <= remaining_q - CNT_W'(1);
            if (last_beat) begin
              wb_valid <= 1'b1;
              wb_dest  <= dest_q;
              wb_data  <= line_ins;
              state_q  <= WRITE;
            end
          end
        end
        WRITE: begin
          line_q     <= '0;
          beat_idx_q <= '0;
          if (!kill && (remaining_q != '0)) begin
            dest_q  <= dest_q + DEST_W'(1);
            state_q <= COLLECT;
          end else begin
            remaining_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_load_writeback.sv
// Testbench for vector_load_writeback: directed table, corner
// sequences and randomized requests against a line-packing model.
module tb_vector_load_writeback;

  localparam int BPR   = 2;
  localparam int MAXB  = 16;
  localparam int NREGS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_dest;
  logic [4:0]  req_beats;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        kill;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [63:0] wb_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  d;
    logic [63:0] w;
  } wr_t;

  wr_t got[$];
  logic [31:0] bts [MAXB];

  typedef struct {
    logic [4:0]  dest;
    int          n;
    logic [31:0] b [4];
    int          exp_n;
    logic [4:0]  d0;
    logic [63:0] w0;
    logic [4:0]  d1;
    logic [63:0] w1;
  } vec_t;

  vec_t tab [4];

  vector_load_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dest  (req_dest),
    .req_beats (req_beats),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_data  (mem_data),
    .kill      (kill),
    .wb_valid  (wb_valid),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (req_valid) begin
      assert (req_beats <= 5'(MAXB)) else $error("req_beats too big");
    end
  end

  always @(posedge clk) begin
    #1;
    if (wb_valid) begin
      got.push_back({wb_dest, wb_data});
      chk("mem_ready_in_write", 64'(mem_ready), 64'd0);
    end
  end

  function automatic logic [63:0] model_line(input int n, input int r);
    logic [63:0] v = '0;
    for (int k = 0; k < BPR; k++) begin
      if (r * BPR + k < n) v[k*32 +: 32] = bts[r*BPR + k];
    end
    return v;
  endfunction

  task automatic check_writes(input string nm, input logic [4:0] d,
                              input int n);
    int nreg = (n + BPR - 1) / BPR;
    int lim;
    chk({nm, "_count"}, 64'(got.size()), 64'(nreg));
    lim = (got.size() < nreg) ? got.size() : nreg;
    for (int r = 0; r < lim; r++) begin
      chk({nm, "_dest"}, 64'(got[r].d), 64'((int'(d) + r) % NREGS));
      chk({nm, "_data"}, got[r].w, model_line(n, r));
    end
  endtask

  task automatic start_req(input logic [4:0] d, input int n);
    int c = 0;
    @(negedge clk);
    while (!req_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_dest  = d;
    req_beats = 5'(n);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_after_req", 64'(busy), 64'(n != 0));
  endtask

  task automatic do_beat(input logic [31:0] d, input bit thr);
    int c = 0;
    bit hs = 1'b0;
    while (!hs && c < 100) begin
      @(negedge clk);
      mem_data  = d;
      mem_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_valid && mem_ready) hs = 1'b1;
      c++;
    end
    if (!hs) chk("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int c = 0;
    @(negedge clk);
    mem_valid = 1'b0;
    while (busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("idle_wait", 64'(busy), 64'd0);
  endtask

  task automatic run(input logic [4:0] d, input int n, input bit thr);
    start_req(d, n);
    for (int i = 0; i < n; i++) do_beat(bts[i], thr);
    wait_idle();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_dest  = '0;
    req_beats = '0;
    mem_valid = 1'b0;
    mem_data  = '0;
    kill      = 1'b0;

    tab[0].dest = 5'd5;  tab[0].n = 2;
    tab[0].b[0] = 32'hAAAA0001; tab[0].b[1] = 32'hBBBB0002;
    tab[0].b[2] = 0; tab[0].b[3] = 0;
    tab[0].exp_n = 1;
    tab[0].d0 = 5'd5; tab[0].w0 = 64'hBBBB0002_AAAA0001;
    tab[0].d1 = 5'd0; tab[0].w1 = 64'd0;

    tab[1].dest = 5'd3;  tab[1].n = 3;
    tab[1].b[0] = 32'h11; tab[1].b[1] = 32'h22;
    tab[1].b[2] = 32'h33; tab[1].b[3] = 0;
    tab[1].exp_n = 2;
    tab[1].d0 = 5'd3; tab[1].w0 = 64'h00000022_00000011;
    tab[1].d1 = 5'd4; tab[1].w1 = 64'h00000000_00000033;

    tab[2].dest = 5'd31; tab[2].n = 4;
    tab[2].b[0] = 32'hC0DE0000; tab[2].b[1] = 32'hC0DE0001;
    tab[2].b[2] = 32'hC0DE0002; tab[2].b[3] = 32'hC0DE0003;
    tab[2].exp_n = 2;
    tab[2].d0 = 5'd31; tab[2].w0 = 64'hC0DE0001_C0DE0000;
    tab[2].d1 = 5'd0;  tab[2].w1 = 64'hC0DE0003_C0DE0002;

    tab[3].dest = 5'd17; tab[3].n = 0;
    tab[3].b[0] = 0; tab[3].b[1] = 0; tab[3].b[2] = 0; tab[3].b[3] = 0;
    tab[3].exp_n = 0;
    tab[3].d0 = 5'd0; tab[3].w0 = 64'd0;
    tab[3].d1 = 5'd0; tab[3].w1 = 64'd0;

    repeat (2) @(negedge clk);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_dest", 64'(wb_dest), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    rst = 1'b0;

    for (int t = 0; t < 4; t++) begin
      got.delete();
      for (int i = 0; i < 4; i++) bts[i] = tab[t].b[i];
      run(tab[t].dest, tab[t].n, t == 2);
      chk("tab_count", 64'(got.size()), 64'(tab[t].exp_n));
      if (got.size() > 0 && tab[t].exp_n > 0) begin
        chk("tab_d0", 64'(got[0].d), 64'(tab[t].d0));
        chk("tab_w0", got[0].w, tab[t].w0);
      end
      if (got.size() > 1 && tab[t].exp_n > 1) begin
        chk("tab_d1", 64'(got[1].d), 64'(tab[t].d1));
        chk("tab_w1", got[1].w, tab[t].w1);
      end
    end

    // kill after one of two beats, with a beat offered on the kill cycle
    got.delete();
    start_req(5'd7, 2);
    do_beat(32'hDEAD0007, 1'b0);
    @(negedge clk);
    kill = 1'b1;
    mem_valid = 1'b1;
    mem_data = 32'hBAD0BAD0;
    @(negedge clk);
    kill = 1'b0;
    mem_valid = 1'b0;
    chk("kill_busy", 64'(busy), 64'd0);
    chk("kill_req_ready", 64'(req_ready), 64'd1);
    repeat (2) @(negedge clk);
    chk("kill_no_write", 64'(got.size()), 64'd0);
    bts[0] = 32'h99990001;
    bts[1] = 32'h99990002;
    run(5'd9, 2, 1'b0);
    check_writes("kill_next", 5'd9, 2);

    // kill while the first of two registers is being written
    got.delete();
    bts[0] = 32'h12120000;
    bts[1] = 32'h12120001;
    start_req(5'd12, 4);
    do_beat(bts[0], 1'b0);
    do_beat(bts[1], 1'b0);
    @(negedge clk);
    mem_valid = 1'b0;
    kill = 1'b1;
    chk("wkill_latency", 64'(wb_valid), 64'd1);
    @(negedge clk);
    kill = 1'b0;
    chk("wkill_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check_writes("wkill", 5'd12, 2);

    // asynchronous reset in the middle of collecting
    got.delete();
    start_req(5'd20, 2);
    do_beat(32'h20200000, 1'b0);
    @(negedge clk);
    mem_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_wb_valid", 64'(wb_valid), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_mem_ready", 64'(mem_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst_no_write", 64'(got.size()), 64'd0);

    // randomized requests, throttled memory side
    for (int t = 0; t < 25; t++) begin
      logic [4:0] d;
      int n;
      got.delete();
      d = 5'($urandom_range(0, NREGS - 1));
      n = $urandom_range(0, MAXB);
      for (int i = 0; i < MAXB; i++) bts[i] = $urandom;
      run(d, n, 1'b1);
      repeat (2) @(negedge clk);
      check_writes("rand", d, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
